// File: rtl/hippo_memory_pkg.sv
// Shared types and constants for the hippo memory load/store unit:
// access sizes, memory byte-lane masks and the LSU state encoding.
package hippo_memory_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;
    localparam logic [3:0] LANE_NONE = 4'b0000;

    function automatic logic [3:0] lane_mask(input access_size_e size);
        case (size)
            BYTE:    lane_mask = LANE_BYTE;
            HALF:    lane_mask = LANE_HALF;
            WORD:    lane_mask = LANE_WORD;
            default: lane_mask = LANE_NONE;
        endcase
    endfunction

    // An illegal size reports zero bytes; callers flag it separately.
    function automatic logic [2:0] size_bytes(input access_size_e size);
        case (size)
            BYTE:    size_bytes = 3'd1;
            HALF:    size_bytes = 3'd2;
            WORD:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/hippo_memory_load_extend.sv
// Masks raw memory read data to the access size and zero- or sign-extends
// it to 32 bits. Purely combinational.
module hippo_memory_load_extend
    import hippo_memory_pkg::*;
(
    input  access_size_e size,
    input  logic         sign_ext,
    input  logic [31:0]  raw_data,
    output logic [31:0]  ext_data
);

    // Select the low lanes and replicate the sign bit when requested.
    always_comb begin
        ext_data = 32'h0000_0000;
        case (size)
            BYTE:    ext_data = {{24{sign_ext & raw_data[7]}}, raw_data[7:0]};
            HALF:    ext_data = {{16{sign_ext & raw_data[15]}}, raw_data[15:0]};
            WORD:    ext_data = raw_data;
            default: ext_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/hippo_memory_lsu.sv
// Load/store unit between a core request port and a single-cycle-latency
// byte-interleaved memory; checks bounds/size and extends load data.
module hippo_memory_lsu
    import hippo_memory_pkg::*;
#(
    parameter int MEMORY_DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH         = $clog2(MEMORY_DEPTH_BYTES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_width_i,
    input  logic                  req_signed_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [3:0]            mem_width_o,
    output logic                  mem_sign_extend_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  mem_we_o,
    input  logic [31:0]           mem_data_i
);

    localparam int EW = ADDR_WIDTH + 3;
    localparam logic [EW-1:0] DEPTH_L = EW'(MEMORY_DEPTH_BYTES);

    lsu_state_e            state_r;
    lsu_state_e            next_state_s;
    logic                  req_we_r;
    access_size_e          req_size_r;
    logic                  req_signed_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_data_r;
    logic [31:0]           rsp_rdata_r;
    logic                  rsp_err_r;

    access_size_e          in_size_s;
    logic [EW-1:0]         end_addr_s;
    logic                  req_err_s;
    logic                  accept_s;
    logic [31:0]           load_ext_s;

    assign in_size_s  = access_size_e'(req_width_i);
    assign accept_s   = req_valid_i & req_ready_o;
    assign end_addr_s = EW'(req_addr_i) + EW'(size_bytes(in_size_s));

    // End address is computed with spare bits so the top-of-memory check cannot wrap.
    always_comb begin
        req_err_s = 1'b0;
        if ((in_size_s == ILLEGAL) || (end_addr_s > DEPTH_L)) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = req_err_s ? RESP : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (req_we_r) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = CAPTURE;
                end
            end
            CAPTURE: next_state_s = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    hippo_memory_load_extend u_load_extend (
        .size     (req_size_r),
        .sign_ext (req_signed_r),
        .raw_data (mem_data_i),
        .ext_data (load_ext_s)
    );

    // State, request capture and response data registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            req_we_r     <= 1'b0;
            req_size_r   <= BYTE;
            req_signed_r <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= 32'h0000_0000;
            rsp_rdata_r  <= 32'h0000_0000;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                req_we_r     <= req_we_i;
                req_size_r   <= in_size_s;
                req_signed_r <= req_signed_i;
                rsp_err_r    <= req_err_s;
                rsp_rdata_r  <= 32'h0000_0000;
                // Rejected requests leave the memory-side address/data untouched.
                if (!req_err_s) begin
                    mem_addr_r <= req_addr_i;
                    mem_data_r <= req_wdata_i;
                end
            end else if (state_r == CAPTURE) begin
                rsp_rdata_r <= load_ext_s;
            end
        end
    end

    // Memory strobes exist only in ISSUE; reset gates the write enable directly.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_width_o = LANE_NONE;
        if (state_r == ISSUE) begin
            mem_width_o = lane_mask(req_size_r);
            mem_we_o    = req_we_r & rst_i;
        end else begin
            mem_width_o = LANE_NONE;
            mem_we_o    = 1'b0;
        end
    end

    assign req_ready_o       = (state_r == IDLE);
    assign rsp_valid_o       = (state_r == RESP);
    assign rsp_rdata_o       = rsp_rdata_r;
    assign rsp_err_o         = rsp_err_r;
    assign mem_sign_extend_o = 1'b0;
    assign mem_addr_o        = mem_addr_r;
    assign mem_data_o        = mem_data_r;

endmodule

// File: tb/tb_hippo_memory_lsu.sv
// Scoreboard bench for hippo_memory_lsu with a behavioural byte memory that
// returns data starting at the presented address, one cycle late.
module tb_hippo_memory_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_width_i;
    logic        req_signed_i;
    logic [9:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [3:0]  mem_width_o;
    logic        mem_sign_extend_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_we_o;
    logic [31:0] mem_data_i;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0]  mem [0:1023];
    int          we_count = 0;
    logic [3:0]  last_we_mask = 4'b0000;

    hippo_memory_lsu #(.MEMORY_DEPTH_BYTES(1024)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_we_i          (req_we_i),
        .req_width_i       (req_width_i),
        .req_signed_i      (req_signed_i),
        .req_addr_i        (req_addr_i),
        .req_wdata_i       (req_wdata_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_rdata_o       (rsp_rdata_o),
        .rsp_err_o         (rsp_err_o),
        .mem_width_o       (mem_width_o),
        .mem_sign_extend_o (mem_sign_extend_o),
        .mem_addr_o        (mem_addr_o),
        .mem_data_o        (mem_data_o),
        .mem_we_o          (mem_we_o),
        .mem_data_i        (mem_data_i)
    );

    always #5 clk = ~clk;

    // Memory model: lane i maps to byte addr+i, write per lane mask, read registered.
    always @(posedge clk) begin
        if (mem_we_o) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_width_o[i]) mem[(int'(mem_addr_o) + i) & 1023] <= mem_data_o[8*i +: 8];
            end
            we_count     <= we_count + 1;
            last_we_mask <= mem_width_o;
        end
        for (int i = 0; i < 4; i++) begin
            mem_data_i[8*i +: 8] <= mem[(int'(mem_addr_o) + i) & 1023];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] width,
                          input logic sgn, input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_we, input logic [3:0] exp_mask, input int hold);
        int   waitc;
        int   lat;
        int   we0;
        exp_t e;
        waitc = 0;
        while (!req_ready_o && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        check_val({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_width_i  = width;
        req_signed_i = sgn;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        sb_q.push_back('{exp_rdata, exp_err, exp_lat});
        we0 = we_count;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = sb_q.pop_front();
        check_val({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check_val({tag, "_rdata"}, rsp_rdata_o, e.rdata);
        check_val({tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
        check_val({tag, "_we_pulses"}, 32'(we_count - we0), 32'(exp_we));
        if (exp_we > 0) check_val({tag, "_mask"}, 32'(last_we_mask), 32'(exp_mask));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
            check_val({tag, "_hold_rdata"}, rsp_rdata_o, e.rdata);
            check_val({tag, "_hold_ready"}, 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        check_val({tag, "_post_valid"}, 32'(rsp_valid_o), 32'd0);
        check_val({tag, "_post_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_width_i  = 2'd0;
        req_signed_i = 1'b0;
        req_addr_i   = 10'd0;
        req_wdata_i  = 32'h0;
        rsp_ready_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;

        check_val("rst_ready",   32'(req_ready_o), 32'd1);
        check_val("rst_valid",   32'(rsp_valid_o), 32'd0);
        check_val("rst_err",     32'(rsp_err_o), 32'd0);
        check_val("rst_rdata",   rsp_rdata_o, 32'h0);
        check_val("rst_width",   32'(mem_width_o), 32'd0);
        check_val("rst_addr",    32'(mem_addr_o), 32'd0);
        check_val("rst_wdata",   mem_data_o, 32'h0);
        check_val("rst_we",      32'(mem_we_o), 32'd0);
        check_val("sign_ext_tie", 32'(mem_sign_extend_o), 32'd0);

        // Word store/load round trip.
        do_req("st_word", 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 4'b1111, 0);
        do_req("ld_word", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 4'b0000, 0);

        // Misaligned half spanning bytes 0x005/0x006.
        do_req("st_b5", 1'b1, 2'd0, 1'b0, 10'h005, 32'h0000_0080, 32'h0, 1'b0, 2, 1, 4'b0001, 0);
        do_req("st_b6", 1'b1, 2'd0, 1'b0, 10'h006, 32'h1234_56FF, 32'h0, 1'b0, 2, 1, 4'b0001, 0);
        do_req("ld_hs", 1'b0, 2'd1, 1'b1, 10'h005, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0, 4'b0000, 0);
        do_req("ld_hu", 1'b0, 2'd1, 1'b0, 10'h005, 32'h0, 32'h0000_FF80, 1'b0, 3, 0, 4'b0000, 0);
        do_req("ld_bs", 1'b0, 2'd0, 1'b1, 10'h005, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 0, 4'b0000, 0);
        do_req("ld_bu", 1'b0, 2'd0, 1'b0, 10'h006, 32'h0, 32'h0000_00FF, 1'b0, 3, 0, 4'b0000, 0);
        do_req("st_half", 1'b1, 2'd1, 1'b0, 10'h041, 32'hAAAA_8001, 32'h0, 1'b0, 2, 1, 4'b0011, 0);
        do_req("ld_halfs", 1'b0, 2'd1, 1'b1, 10'h041, 32'h0, 32'hFFFF_8001, 1'b0, 3, 0, 4'b0000, 0);

        // Top-of-memory boundary.
        do_req("st_top", 1'b1, 2'd2, 1'b0, 10'h3FC, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 4'b1111, 0);
        do_req("st_cross", 1'b1, 2'd2, 1'b0, 10'h3FE, 32'hAABB_CCDD, 32'h0, 1'b1, 1, 0, 4'b0000, 0);
        do_req("ld_top", 1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0, 32'h1122_3344, 1'b0, 3, 0, 4'b0000, 0);
        do_req("ld_h3fe", 1'b0, 2'd1, 1'b0, 10'h3FE, 32'h0, 32'h0000_1122, 1'b0, 3, 0, 4'b0000, 0);
        do_req("st_h3ff", 1'b1, 2'd1, 1'b0, 10'h3FF, 32'h5555_5555, 32'h0, 1'b1, 1, 0, 4'b0000, 0);
        do_req("ld_b3ff", 1'b0, 2'd0, 1'b0, 10'h3FF, 32'h0, 32'h0000_0011, 1'b0, 3, 0, 4'b0000, 0);

        // Illegal width, load and store.
        do_req("ld_ill", 1'b0, 2'd3, 1'b1, 10'h010, 32'h0, 32'h0, 1'b1, 1, 0, 4'b0000, 0);
        do_req("st_ill", 1'b1, 2'd3, 1'b0, 10'h010, 32'h0BAD_0BAD, 32'h0, 1'b1, 1, 0, 4'b0000, 0);
        do_req("ld_after_ill", 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 4'b0000, 0);

        // Response backpressure, then an immediate follow-on request.
        do_req("ld_bp", 1'b0, 2'd0, 1'b0, 10'h010, 32'h0, 32'h0000_00EF, 1'b0, 3, 0, 4'b0000, 5);
        do_req("ld_next", 1'b0, 2'd1, 1'b1, 10'h011, 32'h0, 32'hFFFF_ADBE, 1'b0, 3, 0, 4'b0000, 0);

        // Reset asserted during ISSUE of a store.
        do_req("st_old", 1'b1, 2'd2, 1'b0, 10'h020, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 4'b1111, 0);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_width_i = 2'd2;
        req_addr_i  = 10'h020;
        req_wdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        check_val("rstmid_we_issue", 32'(mem_we_o), 32'd1);
        check_val("rstmid_width_issue", 32'(mem_width_o), 32'hF);
        rst_i = 1'b0;
        #1;
        check_val("rstmid_we_forced", 32'(mem_we_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        check_val("rstmid_idle_ready", 32'(req_ready_o), 32'd1);
        check_val("rstmid_idle_valid", 32'(rsp_valid_o), 32'd0);
        do_req("ld_old", 1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 32'h1234_5678, 1'b0, 3, 0, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/hippo_memory_lsu.md
HIPPO_MEMORY_LSU -- requirements
Module: hippo_memory_lsu

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH_BYTES, default 1024: byte size of the attached interleaved memory.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default $clog2(MEMORY_DEPTH_BYTES): byte address width.
REQ-003 The block SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid_i / req_ready_o, in/out, 1 each: request handshake from the core.
REQ-006 The block SHALL have port req_we_i, input, 1: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_width_i, input, 2: access size, 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 The block SHALL have port req_signed_i, input, 1: sign-extend the load result.
REQ-009 The block SHALL have port req_addr_i, input, ADDR_WIDTH: byte address, any alignment.
REQ-010 The block SHALL have port req_wdata_i, input, 32: store data, LSB-aligned.
REQ-011 The block SHALL have port rsp_valid_o / rsp_ready_i, out/in, 1 each: response handshake.
REQ-012 The block SHALL have port rsp_rdata_o, output, 32: load result; 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err_o, output, 1: the access was rejected.
REQ-014 The block SHALL have port mem_width_o, output, 4: byte-lane mask to the memory, 0001 / 0011 / 1111.
REQ-015 The block SHALL have port mem_sign_extend_o, output, 1: tied to 0; the LSU extends loads itself.
REQ-016 The block SHALL have ports mem_addr_o (ADDR_WIDTH), mem_data_o (32) and mem_we_o (1), outputs: memory address, write data and write enable.
REQ-017 The block SHALL have port mem_data_i, input, 32: raw memory read data, valid one cycle after its address is presented.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, ISSUE, CAPTURE and RESP.
REQ-019 req_ready_o SHALL be 1 only in IDLE; the request is accepted when req_valid_i & req_ready_o, and all request fields are registered at acceptance.
REQ-020 An accepted request SHALL be in error if req_width_i == 3, or if addr + size > MEMORY_DEPTH_BYTES (size = 1, 2 or 4 bytes).
REQ-021 An error request SHALL go IDLE->RESP with rsp_err_o = 1 and SHALL never reach the memory.
REQ-022 A legal request SHALL go IDLE->ISSUE; during ISSUE the mem_* outputs are driven from the registered request.
REQ-023 mem_we_o SHALL be 1 only during ISSUE of a store, for exactly one cycle.
REQ-024 A store SHALL go ISSUE->RESP; a load SHALL go ISSUE->CAPTURE->RESP.
REQ-025 In CAPTURE the block SHALL register mem_data_i, masked to the access size and zero- or sign-extended per req_signed.
REQ-026 rsp_valid_o SHALL be 1 only in RESP; RESP->IDLE on rsp_ready_i, otherwise rsp_valid_o and rsp_* hold stable.
REQ-027 Latency from the acceptance edge to rsp_valid_o SHALL be: load 3 cycles, store 2, error 1.
REQ-028 Outside ISSUE the block SHALL drive mem_we_o = 0 and mem_width_o = 0000; mem_addr_o and mem_data_o hold their last value.
REQ-029 Word-misaligned accesses that do not cross the top of memory SHALL be issued as a single access; lane rotation is the memory's job.
REQ-030 A new request SHALL be accepted no earlier than the cycle after the RESP handshake (no bypass).

Reset
REQ-031 While rst_i == 0, mem_we_o SHALL be forced 0 combinationally, so a store in flight is never committed during reset.
REQ-032 On a clock edge with rst_i == 0, the block SHALL enter IDLE, including from mid-operation.
REQ-033 After reset: rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0, mem_width_o = 0000, mem_addr_o = 0, mem_data_o = 0, and req_ready_o = 1 on the first cycle after reset is released.

Structure
REQ-034 Package hippo_memory_pkg SHALL hold the access-size enum (BYTE, HALF, WORD, ILLEGAL), the lane-mask constants 0001 / 0011 / 1111 and the LSU state typedef.
REQ-035 Load masking and extension SHALL live in one combinational sub-module, hippo_memory_load_extend (inputs size, signed flag, raw data; output extended data).

Verification
REQ-036 Aligned word store then load: store 0xDEADBEEF at 0x010, then load word at 0x010 -> mem_we_o pulses once with mem_width_o = 1111; rsp_rdata_o = 0xDEADBEEF, 3 cycles after acceptance.
REQ-037 Misaligned signed half load: memory bytes 0x80 at 0x005 and 0xFF at 0x006, signed half load at 0x005 -> rsp_rdata_o = 0xFFFFFF80; the unsigned load returns 0x0000FF80.
REQ-038 Top-of-memory crossing: word store at 0x3FE with depth 1024 -> rsp_err_o = 1 one cycle after acceptance, mem_we_o never asserted; the memory is unchanged on readback.
REQ-039 Illegal width: req_width_i = 3 -> rsp_err_o = 1, rsp_rdata_o = 0, no mem_we_o.
REQ-040 Response backpressure: rsp_ready_i held low for 5 cycles on a byte load -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0; the next request is accepted the cycle after the handshake.
REQ-041 Reset mid-store: rst_i low during ISSUE of a store -> mem_we_o = 0 in that cycle, state is IDLE next cycle, and readback shows the old data.
